// File: rtl/env_write_sched.sv
// Single write-port scheduler for the environment. Ant writes are arbitrated
// round-robin; a periodic sweep decays every location by one via read-modify-write.
module env_write_sched #(
  parameter int N_ANTS       = 4,
  parameter int X_bits       = 6,
  parameter int Y_bits       = 5,
  parameter int PIXELS_X     = 64,
  parameter int PIXELS_Y     = 32,
  parameter int SIGNAL_bits  = 4,
  parameter int DECAY_PERIOD = 1024
) (
  input  logic                                   Clk,
  input  logic                                   RESET_SIM_n,
  input  logic [N_ANTS-1:0]                      req,
  input  logic [N_ANTS-1:0][X_bits-1:0]          req_X,
  input  logic [N_ANTS-1:0][Y_bits-1:0]          req_Y,
  input  logic [N_ANTS-1:0][SIGNAL_bits-1:0]     req_signal,
  input  logic [N_ANTS-1:0]                      req_sugar,
  output logic [N_ANTS-1:0]                      grant,
  output logic                                   write_en,
  output logic [X_bits-1:0]                      write_X,
  output logic [Y_bits-1:0]                      write_Y,
  output logic [SIGNAL_bits-1:0]                 write_signal,
  output logic                                   write_sugar,
  output logic [X_bits-1:0]                      lookup_X,
  output logic [Y_bits-1:0]                      lookup_Y,
  input  logic [SIGNAL_bits:0]                   lookup_data,
  output logic                                   sweep_busy,
  output logic                                   sweep_done
);

  localparam int RRW = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;
  localparam int CW  = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [X_bits-1:0] X_MAX   = X_bits'(PIXELS_X - 1);
  localparam logic [Y_bits-1:0] Y_MAX   = Y_bits'(PIXELS_Y - 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(DECAY_PERIOD - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [X_bits-1:0]       ptr_x_q, ptr_x_d;
  logic [Y_bits-1:0]       ptr_y_q, ptr_y_d;
  logic [RRW-1:0]          rr_q, rr_d;
  logic [N_ANTS-1:0]       grant_q, grant_d;
  logic                    we_q, we_d;
  logic [X_bits-1:0]       wx_q, wx_d;
  logic [Y_bits-1:0]       wy_q, wy_d;
  logic [SIGNAL_bits-1:0]  ws_q, ws_d;
  logic                    wsug_q, wsug_d;
  logic                    done_q, done_d;

  logic [N_ANTS-1:0]       elig;
  logic                    any_elig, win_found, decay_take, ant_take, fwd, ptr_last;
  logic [RRW-1:0]          win_idx;
  logic [SIGNAL_bits:0]    src;
  logic [SIGNAL_bits-1:0]  dec_sig;
  int                      idx;

  // Round-robin pick: first eligible ant at or after the pointer.
  always_comb begin
    elig      = req & ~grant_q;
    any_elig  = |elig;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_ANTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_ANTS) idx = idx - N_ANTS;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = RRW'(idx);
      end
    end
  end

  // Forward the in-flight write when it targets the location being decayed.
  always_comb begin
    fwd      = we_q && (wx_q == ptr_x_q) && (wy_q == ptr_y_q);
    src      = fwd ? {ws_q, wsug_q} : lookup_data;
    dec_sig  = (src[SIGNAL_bits:1] == '0) ? '0 : src[SIGNAL_bits:1] - 1'b1;
    ptr_last = (ptr_x_q == X_MAX) && (ptr_y_q == Y_MAX);
    // Decay takes the slot when nobody else wants it or an ant just had it.
    decay_take = (state_q == SWEEP) && (!any_elig || (|grant_q));
    ant_take   = any_elig && !decay_take;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_x_d = ptr_x_q;
    ptr_y_d = ptr_y_q;
    rr_d    = rr_q;
    grant_d = '0;
    we_d    = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    ws_d    = ws_q;
    wsug_d  = wsug_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = SWEEP;
          ptr_x_d = '0;
          ptr_y_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SWEEP: begin
        if (decay_take) begin
          we_d   = 1'b1;
          wx_d   = ptr_x_q;
          wy_d   = ptr_y_q;
          ws_d   = dec_sig;
          wsug_d = src[0];
          if (ptr_x_q == X_MAX) begin
            ptr_x_d = '0;
            ptr_y_d = (ptr_y_q == Y_MAX) ? '0 : ptr_y_q + 1'b1;
          end else begin
            ptr_x_d = ptr_x_q + 1'b1;
          end
          if (ptr_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ant_take) begin
      we_d             = 1'b1;
      grant_d[win_idx] = 1'b1;
      wx_d             = req_X[win_idx];
      wy_d             = req_Y[win_idx];
      ws_d             = req_signal[win_idx];
      wsug_d           = req_sugar[win_idx];
      rr_d             = (win_idx == RRW'(N_ANTS - 1)) ? '0 : RRW'(win_idx + 1'b1);
    end
  end

  always_ff @(posedge Clk or negedge RESET_SIM_n) begin
    if (!RESET_SIM_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_x_q <= '0;
      ptr_y_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      ws_q    <= '0;
      wsug_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_x_q <= ptr_x_d;
      ptr_y_q <= ptr_y_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      ws_q    <= ws_d;
      wsug_q  <= wsug_d;
      done_q  <= done_d;
    end
  end

  assign grant        = grant_q;
  assign write_en     = we_q;
  assign write_X      = wx_q;
  assign write_Y      = wy_q;
  assign write_signal = ws_q;
  assign write_sugar  = wsug_q;
  assign lookup_X     = ptr_x_q;
  assign lookup_Y     = ptr_y_q;
  assign sweep_busy   = (state_q == SWEEP);
  assign sweep_done   = done_q;

endmodule

// File: tb/tb_env_write_sched.sv
// Scoreboard bench for env_write_sched: directed stimulus pushes expected port
// writes (with cycle stamps), a negedge monitor pops and compares them.
module tb_env_write_sched;
  localparam int NA = 4, XB = 6, YB = 5, PX = 64, PY = 32, SB = 4, DP = 8;
  localparam int NLOC = PX * PY;

  logic                    Clk = 1'b0;
  logic                    RESET_SIM_n = 1'b0;
  logic [NA-1:0]           req;
  logic [NA-1:0][XB-1:0]   req_X;
  logic [NA-1:0][YB-1:0]   req_Y;
  logic [NA-1:0][SB-1:0]   req_signal;
  logic [NA-1:0]           req_sugar;
  logic [NA-1:0]           grant;
  logic                    write_en, write_sugar, sweep_busy, sweep_done;
  logic [XB-1:0]           write_X, lookup_X;
  logic [YB-1:0]           write_Y, lookup_Y;
  logic [SB-1:0]           write_signal;
  logic [SB:0]             lookup_data;

  env_write_sched #(.N_ANTS(NA), .X_bits(XB), .Y_bits(YB), .PIXELS_X(PX),
                    .PIXELS_Y(PY), .SIGNAL_bits(SB), .DECAY_PERIOD(DP)) dut (
    .Clk(Clk), .RESET_SIM_n(RESET_SIM_n), .req(req), .req_X(req_X), .req_Y(req_Y),
    .req_signal(req_signal), .req_sugar(req_sugar), .grant(grant), .write_en(write_en),
    .write_X(write_X), .write_Y(write_Y), .write_signal(write_signal),
    .write_sugar(write_sugar), .lookup_X(lookup_X), .lookup_Y(lookup_Y),
    .lookup_data(lookup_data), .sweep_busy(sweep_busy), .sweep_done(sweep_done));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] c; logic [3:0] g; logic [5:0] x; logic [4:0] y;
    logic [3:0] s; logic u; logic b; logic d;
  } exp_t;

  exp_t q[$];
  exp_t e, got;
  int   vecs = 0, errs = 0, cyc = 0, base = 0;
  int   fill_mode = 0;
  logic fill_req = 1'b0;
  logic [4:0] mem [PY][PX];

  function automatic logic [4:0] init_val(int m, int x, int y);
    case (m)
      0:       return 5'd0;
      1:       return (x == 7 && y == 5) ? 5'b00001 : {4'd3, 1'(x ^ y)};
      2:       return {4'd3, 1'(x)};
      default: return {4'd3, 1'b0};
    endcase
  endfunction

  // Environment model: combinational lookup, write captured at the clock edge.
  assign lookup_data = mem[lookup_Y][lookup_X];
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (fill_req) begin
      for (int y = 0; y < PY; y++)
        for (int x = 0; x < PX; x++) mem[y][x] <= init_val(fill_mode, x, y);
    end else if (write_en) begin
      mem[write_Y][write_X] <= {write_signal, write_sugar};
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h need %h (cycle %0d)", nm, act, exp, cyc - base);
    end
  endtask

  always @(negedge Clk) begin
    if (RESET_SIM_n) begin
      if (!write_en) begin
        chk("idle_grant_done", {grant, sweep_done}, '0);
      end else if (q.size() == 0) begin
        chk("unexpected_write", 64'(write_en), 64'd0);
      end else begin
        e   = q.pop_front();
        got = '{16'(cyc - base), grant, write_X, write_Y, write_signal, write_sugar,
                sweep_busy, sweep_done};
        chk("write", got, e);
      end
    end
  end

  function automatic exp_t mk(int c, int g, int x, int y, int s, int u, int b, int d);
    return '{16'(c), 4'(g), 6'(x), 5'(y), 4'(s), 1'(u), 1'(b), 1'(d)};
  endfunction

  task automatic push_decay(int i, int c, int m);
    logic [4:0] v;
    v = init_val(m, i % PX, i / PX);
    q.push_back(mk(c, 0, i % PX, i / PX, (v[4:1] == 0) ? 0 : v[4:1] - 1, v[0],
                   i != NLOC - 1, i == NLOC - 1));
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_empty(string nm, int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk(nm, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic rst_on();
    RESET_SIM_n = 1'b0;
    req = '0; req_X = '0; req_Y = '0; req_signal = '0; req_sugar = '0;
    #1;
    chk("reset_outputs", {write_en, grant, sweep_busy, sweep_done, write_X, write_Y,
                          write_signal, write_sugar, lookup_X, lookup_Y}, '0);
  endtask

  // mode < 0 keeps the environment contents across the reset.
  task automatic rst_off(int mode);
    if (mode >= 0) begin
      fill_mode = mode;
      fill_req  = 1'b1;
      @(posedge Clk);
      #1 fill_req = 1'b0;
    end
    tick();
    RESET_SIM_n = 1'b1;
    base = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    rst_on();
    rst_off(0);

    // Ants 0 and 2 held: 0, 2, 0 with no back-to-back double grant.
    req = 4'b0101;
    req_X[0] = 6'd3;  req_Y[0] = 5'd4;  req_signal[0] = 4'd5;  req_sugar[0] = 1'b1;
    req_X[2] = 6'd60; req_Y[2] = 5'd31; req_signal[2] = 4'd15; req_sugar[2] = 1'b0;
    q.push_back(mk(1, 4'b0001, 3, 4, 5, 1, 0, 0));
    q.push_back(mk(2, 4'b0100, 60, 31, 15, 0, 0, 0));
    q.push_back(mk(3, 4'b0001, 3, 4, 5, 1, 0, 0));
    wait_empty("t1_rr_drain", 10);
    rst_on();

    // Full sweep, no ants; includes a signal=0,sugar=1 location at (7,5).
    rst_off(1);
    for (int i = 0; i < NLOC; i++) push_decay(i, 9 + i, 1);
    wait_empty("t2_sweep_drain", NLOC + 20);
    tick();
    chk("t2_idle_after", 64'(sweep_busy), 64'd0);
    rst_on();

    // Ant write to (5,0) lands the cycle decay reads (5,0): must forward 9 -> 8.
    rst_off(2);
    for (int i = 0; i < 5; i++) push_decay(i, 9 + i, 2);
    q.push_back(mk(14, 4'b0001, 5, 0, 9, 0, 1, 0));
    q.push_back(mk(15, 0, 5, 0, 8, 0, 1, 0));
    for (int i = 6; i < NLOC; i++) push_decay(i, 10 + i, 2);
    repeat (13) tick();
    chk("t4_lookup", {lookup_X, lookup_Y}, {6'd5, 5'd0});
    req = 4'b0001; req_X[0] = 6'd5; req_Y[0] = 5'd0; req_signal[0] = 4'd9; req_sugar[0] = 1'b0;
    tick();
    req = '0;
    wait_empty("t4_fwd_drain", NLOC + 20);
    rst_on();

    // All ants requesting throughout the sweep: decay every other slot.
    rst_off(3);
    push_decay(0, 9, 3);
    for (int k = 1; k < NLOC; k++) begin
      q.push_back(mk(8 + 2 * k, 1 << ((k - 1) % 4), 10 + (k - 1) % 4, 20 + (k - 1) % 4,
                     3, 0, 1, 0));
      push_decay(k, 9 + 2 * k, 3);
    end
    repeat (9) tick();
    for (int a = 0; a < NA; a++) begin
      req_X[a] = 6'(10 + a); req_Y[a] = 5'(20 + a); req_signal[a] = 4'd3; req_sugar[a] = 1'b0;
    end
    req = 4'b1111;
    for (int n = 0; n < 2 * NLOC + 50 && !sweep_done; n++) tick();
    req = '0;
    chk("t5_done_seen", 64'(sweep_done), 64'd1);
    wait_empty("t5_drain", 20);
    rst_on();

    // Reset mid-sweep at (10,3); the next sweep restarts from (0,0).
    rst_off(3);
    for (int i = 0; i < 202; i++) push_decay(i, 9 + i, 3);
    repeat (210) tick();
    chk("t6_lookup", {lookup_X, lookup_Y}, {6'd10, 5'd3});
    rst_on();
    chk("t6_pending", 64'(q.size()), 64'd0);
    rst_off(-1);
    for (int i = 0; i < 4; i++) q.push_back(mk(9 + i, 0, i, 0, 1, 0, 1, 0));
    wait_empty("t6_restart_drain", 30);
    rst_on();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
